// File: rtl/fill_pkg.sv
// Shared definitions for the framebuffer rectangle-fill engine: FSM states,
// register indices, framebuffer geometry and TileLink-UL opcode constants.
package fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } fill_state_e;

  // APB register indices, selected by PADDR[4:2]
  localparam logic [2:0] REG_CTRL  = 3'd0;
  localparam logic [2:0] REG_DST   = 3'd1;
  localparam logic [2:0] REG_SIZE  = 3'd2;
  localparam logic [2:0] REG_COLOR = 3'd3;

  // Framebuffer line layout shared with the video controller
  localparam int unsigned LINE_STRIDE     = 4096;
  localparam int unsigned MAX_OUTSTANDING = 4;

  // TileLink-UL constants shared with the other TL masters
  localparam logic [2:0] PUT_FULL   = 3'd0;
  localparam logic [2:0] ACCESS_ACK = 3'd0;
  localparam logic [2:0] BLOCK_SIZE_LOG2 = 3'd6;  // 64-byte bursts

endpackage

// File: rtl/fill_apb_regs.sv
// APB register file of the fill engine: DST/SIZE/COLOR storage, start pulse
// generation, write blocking while a fill runs, and the read-data mux.
module fill_apb_regs
  import fill_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  paddr_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  input  logic        busy_i,
  input  logic        err_i,
  output logic [31:0] prdata_o,
  output logic [25:0] dst_o,
  output logic [6:0]  width_o,
  output logic [9:0]  height_o,
  output logic [15:0] color_o,
  output logic        start_o
);

  logic [2:0]  reg_idx;
  logic        wr_en;
  logic [25:0] dst_q;
  logic [6:0]  width_q;
  logic [9:0]  height_q;
  logic [15:0] color_q;
  logic        unused_paddr;

  assign reg_idx      = paddr_i[4:2];
  assign unused_paddr = ^paddr_i[1:0];

  // Register writes land in the APB access phase and are dropped while busy
  assign wr_en   = psel_i & penable_i & pwrite_i & ~busy_i;
  assign start_o = wr_en && (reg_idx == REG_CTRL) && pwdata_i[0];

  // Configuration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      color_q  <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        REG_DST:   dst_q <= pwdata_i[31:6];
        REG_SIZE: begin
          width_q  <= pwdata_i[6:0];
          height_q <= pwdata_i[25:16];
        end
        REG_COLOR: color_q <= pwdata_i[15:0];
        default: ;
      endcase
    end
  end

  // Combinational read-data mux
  always_comb begin
    prdata_o = '0;
    case (reg_idx)
      REG_CTRL:  prdata_o = {30'b0, err_i, busy_i};
      REG_DST:   prdata_o = {dst_q, 6'b0};
      REG_SIZE:  prdata_o = {6'b0, height_q, 9'b0, width_q};
      REG_COLOR: prdata_o = {16'b0, color_q};
      default:   prdata_o = '0;
    endcase
  end

  assign dst_o    = dst_q;
  assign width_o  = width_q;
  assign height_o = height_q;
  assign color_o  = color_q;

endmodule

// File: rtl/framebuffer_fill.sv
// Rectangle-fill engine: walks a width x height grid of 64-byte blocks and
// issues one 8-beat TileLink-UL PutFullData burst per block, keeping at most
// four bursts unacknowledged. Optional completion interrupt: FILL_IRQ_EN.
module framebuffer_fill
  import fill_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  apb_PADDR,
  input  logic        apb_PSEL,
  input  logic        apb_PENABLE,
  input  logic        apb_PWRITE,
  input  logic [31:0] apb_PWDATA,
  output logic        apb_PREADY,
  output logic [31:0] apb_PRDATA,
  output logic        tl_bus_a_valid,
  input  logic        tl_bus_a_ready,
  output logic [2:0]  tl_bus_a_payload_opcode,
  output logic [2:0]  tl_bus_a_payload_param,
  output logic [2:0]  tl_bus_a_payload_source,
  output logic [2:0]  tl_bus_a_payload_size,
  output logic [31:0] tl_bus_a_payload_address,
  output logic [63:0] tl_bus_a_payload_data,
  output logic [7:0]  tl_bus_a_payload_mask,
  input  logic        tl_bus_d_valid,
  output logic        tl_bus_d_ready,
  input  logic        tl_bus_d_payload_denied
`ifdef FILL_IRQ_EN
  ,
  output logic        irq
`endif
);

  fill_state_e state_q, state_d;
  logic [25:0] dst_w;
  logic [6:0]  width_w;
  logic [9:0]  height_w;
  logic [15:0] color_w;
  logic        start;
  logic        busy;
  logic        err_q;
  logic [31:0] row_base_q;
  logic [6:0]  col_q;
  logic [9:0]  row_q;
  logic [2:0]  beat_q;
  logic [1:0]  tag_q;
  logic [2:0]  outstanding_q, outstanding_d;
  logic        start_go, zero_start;
  logic        a_fire, last_beat, last_col, last_row;
  logic        inc, dec;

  fill_apb_regs u_regs (
    .clk       (clk),
    .reset     (reset),
    .paddr_i   (apb_PADDR),
    .psel_i    (apb_PSEL),
    .penable_i (apb_PENABLE),
    .pwrite_i  (apb_PWRITE),
    .pwdata_i  (apb_PWDATA),
    .busy_i    (busy),
    .err_i     (err_q),
    .prdata_o  (apb_PRDATA),
    .dst_o     (dst_w),
    .width_o   (width_w),
    .height_o  (height_w),
    .color_o   (color_w),
    .start_o   (start)
  );

  assign busy       = (state_q != IDLE);
  assign zero_start = start && ((width_w == 7'd0) || (height_w == 10'd0));
  assign start_go   = start && !zero_start;

  assign a_fire    = tl_bus_a_valid & tl_bus_a_ready;
  assign last_beat = a_fire && (beat_q == 3'd7);
  assign last_col  = (col_q == width_w - 7'd1);
  assign last_row  = (row_q == height_w - 10'd1);

  // Stray acks after a mid-fill reset must not underflow the counter
  assign inc = last_beat;
  assign dec = tl_bus_d_valid && ((outstanding_q != 3'd0) || inc);
  assign outstanding_d = outstanding_q + {2'b0, inc} - {2'b0, dec};

  // Next-state logic of the fill sequencer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_go) state_d = SEND;
      SEND: begin
        if (last_beat) begin
          if (last_col && last_row)
            state_d = DRAIN;
          else if (outstanding_d == 3'(MAX_OUTSTANDING))
            state_d = STALL;
        end
      end
      STALL: if (outstanding_q < 3'(MAX_OUTSTANDING)) state_d = SEND;
      DRAIN: if (outstanding_q == 3'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Block walker, burst tag, outstanding counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_base_q    <= '0;
      col_q         <= '0;
      row_q         <= '0;
      beat_q        <= '0;
      tag_q         <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      if (start) err_q <= 1'b0;
      if (tl_bus_d_valid && tl_bus_d_payload_denied) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (start_go) begin
            row_base_q <= {dst_w, 6'b0};
            col_q      <= '0;
            row_q      <= '0;
            beat_q     <= '0;
            tag_q      <= '0;
          end
        end
        SEND: begin
          if (a_fire) begin
            beat_q <= beat_q + 3'd1;
            if (beat_q == 3'd7) begin
              tag_q <= tag_q + 2'd1;
              if (last_col) begin
                col_q      <= '0;
                row_base_q <= row_base_q + 32'(LINE_STRIDE);
                row_q      <= row_q + 10'd1;
              end else begin
                col_q <= col_q + 7'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign apb_PREADY               = 1'b1;
  assign tl_bus_a_valid           = (state_q == SEND);
  assign tl_bus_a_payload_opcode  = PUT_FULL;
  assign tl_bus_a_payload_param   = 3'd0;
  assign tl_bus_a_payload_source  = {1'b0, tag_q};
  assign tl_bus_a_payload_size    = BLOCK_SIZE_LOG2;
  assign tl_bus_a_payload_address = row_base_q + {19'b0, col_q, 6'b0};
  assign tl_bus_a_payload_data    = {4{color_w}};
  assign tl_bus_a_payload_mask    = 8'hFF;
  assign tl_bus_d_ready           = 1'b1;

`ifdef FILL_IRQ_EN
  logic irq_q;

  // One-clock pulse after the last ack drains or after an empty start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= ((state_q == DRAIN) && (state_d == IDLE)) || zero_start;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_framebuffer_fill.sv
// Self-checking bench for framebuffer_fill: expected beats are queued when a
// fill is programmed and compared on every cycle the A channel is valid.
`timescale 1ns/1ps
module tb_framebuffer_fill;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        a_valid;
  logic        a_ready = 1'b0;
  logic [2:0]  a_opcode, a_param, a_source, a_size;
  logic [31:0] a_address;
  logic [63:0] a_data;
  logic [7:0]  a_mask;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic        d_denied = 1'b0;
`ifdef FILL_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  framebuffer_fill dut (
    .clk                      (clk),
    .reset                    (reset),
    .apb_PADDR                (paddr),
    .apb_PSEL                 (psel),
    .apb_PENABLE              (penable),
    .apb_PWRITE               (pwrite),
    .apb_PWDATA               (pwdata),
    .apb_PREADY               (pready),
    .apb_PRDATA               (prdata),
    .tl_bus_a_valid           (a_valid),
    .tl_bus_a_ready           (a_ready),
    .tl_bus_a_payload_opcode  (a_opcode),
    .tl_bus_a_payload_param   (a_param),
    .tl_bus_a_payload_source  (a_source),
    .tl_bus_a_payload_size    (a_size),
    .tl_bus_a_payload_address (a_address),
    .tl_bus_a_payload_data    (a_data),
    .tl_bus_a_payload_mask    (a_mask),
    .tl_bus_d_valid           (d_valid),
    .tl_bus_d_ready           (d_ready),
    .tl_bus_d_payload_denied  (d_denied)
`ifdef FILL_IRQ_EN
    ,
    .irq                      (irq)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  src;
  } beat_t;

  beat_t       exp_q[$];
  longint      ack_due[$];
  int          n_checks = 0;
  int          n_errors = 0;
  longint      cyc = 0;
  int          beat_cnt = 0;
  int          beats_acc = 0;
  int          blocks_sent = 0;
  int          acks_sent = 0;
  int          deny_at = -1;
  int          ack_credit = 0;
  bit          hold_acks = 1'b0;
  bit          rand_ready = 1'b0;
  int          irq_hi = 0;
  logic [15:0] exp_color = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // A-channel scoreboard, ready generator and ack responder (negedge)
  always @(negedge clk) begin
    cyc++;
    d_valid  = 1'b0;
    d_denied = 1'b0;
    a_ready  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef FILL_IRQ_EN
    if (irq === 1'b1) irq_hi++;
`endif
    if (!reset) begin
      if (a_valid) begin
        if (exp_q.size() == 0) begin
          check_val("a_unexpected", 64'(a_valid), 64'd0);
        end else begin
          check_val("a_addr", 64'(a_address), 64'(exp_q[0].addr));
          check_val("a_data", a_data, {4{exp_color}});
          check_val("a_source", 64'(a_source), 64'(exp_q[0].src));
          check_val("a_hdr", 64'({a_opcode, a_param, a_size, a_mask}),
                    64'({3'd0, 3'd0, 3'd6, 8'hFF}));
        end
        if (a_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          beats_acc++;
          if (beat_cnt == 7) begin
            blocks_sent++;
            ack_due.push_back(cyc + 3);
          end
          beat_cnt = (beat_cnt + 1) % 8;
        end
      end
      if (ack_due.size() > 0 && ack_due[0] <= cyc && (!hold_acks || ack_credit > 0)) begin
        if (hold_acks) ack_credit--;
        d_valid  = 1'b1;
        d_denied = (acks_sent == deny_at);
        void'(ack_due.pop_front());
        acks_sent++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_write(input logic [2:0] idx, input logic [31:0] d);
    paddr = {idx, 2'b00}; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] idx, output logic [31:0] d);
    paddr = {idx, 2'b00}; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    tick(1);
    penable = 1'b1;
    d = prdata;
    tick(1);
    psel = 1'b0; penable = 1'b0;
  endtask

  // Program a fill, queue its expected beats, then start it
  task automatic start_fill(input logic [31:0] dst, input int w, input int h, input logic [15:0] color);
    logic [31:0] base;
    int blk;
    base = dst & 32'hFFFF_FFC0;
    apb_write(3'd1, dst);
    apb_write(3'd2, {6'b0, 10'(h), 9'b0, 7'(w)});
    apb_write(3'd3, {16'b0, color});
    exp_color = color;
    blk = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        for (int b = 0; b < 8; b++)
          exp_q.push_back('{addr: base + 32'(r) * 32'd4096 + 32'(c) * 32'd64,
                            src: 3'(blk % 4)});
        blk++;
      end
    end
    apb_write(3'd0, 32'd1);
    if (w != 0 && h != 0) check_val("start_a_valid", 64'(a_valid), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n;
    n = 0;
    apb_read(3'd0, s);
    while (s[0] && n < 3000) begin
      apb_read(3'd0, s);
      n++;
    end
    check_val({tag, "_done"}, 64'(s[0]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int b0, k0, a0, i0, n;

    // Reset state
    reset = 1'b1;
    tick(3);
    check_val("rst_a_valid", 64'(a_valid), 64'd0);
    check_val("rst_address", 64'(a_address), 64'd0);
`ifdef FILL_IRQ_EN
    check_val("rst_irq", 64'(irq), 64'd0);
`endif
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      apb_read(3'(i), rd);
      check_val($sformatf("rst_reg%0d", i), 64'(rd), 64'd0);
    end

    // Basic 2x2 fill, prompt acks
    a0 = acks_sent; b0 = beats_acc; i0 = irq_hi;
    start_fill(32'h0010_0000, 2, 2, 16'hF800);
    wait_idle("t1");
    check_val("t1_acks_at_idle", 64'(acks_sent - a0), 64'd4);
    check_val("t1_beats", 64'(beats_acc - b0), 64'd32);
    check_val("t1_queue_left", 64'(exp_q.size()), 64'd0);
    apb_read(3'd0, rd);
    check_val("t1_status", 64'(rd), 64'd0);
    apb_read(3'd2, rd);
    check_val("t1_size_rb", 64'(rd), 64'h0002_0002);
    tick(3);
`ifdef FILL_IRQ_EN
    check_val("t1_irq_cycles", 64'(irq_hi - i0), 64'd1);
`endif

    // Acks withheld: stops after 4 bursts, one ack releases the 5th
    hold_acks = 1'b1; ack_credit = 0;
    k0 = blocks_sent;
    start_fill(32'h0020_0000, 8, 1, 16'h07E0);
    tick(120);
    check_val("t2_bursts_held", 64'(blocks_sent - k0), 64'd4);
    check_val("t2_a_valid_held", 64'(a_valid), 64'd0);
    apb_read(3'd0, rd);
    check_val("t2_busy_held", 64'(rd), 64'd1);
    ack_credit = 1;
    tick(40);
    check_val("t2_bursts_one_ack", 64'(blocks_sent - k0), 64'd5);
    check_val("t2_a_valid_stall", 64'(a_valid), 64'd0);
    hold_acks = 1'b0;
    wait_idle("t2");
    check_val("t2_bursts_total", 64'(blocks_sent - k0), 64'd8);
    check_val("t2_queue_left", 64'(exp_q.size()), 64'd0);

    // Random ready; second fill wraps the 32-bit address space
    rand_ready = 1'b1;
    b0 = beats_acc;
    start_fill(32'h0000_3FC0, 3, 2, 16'hA5A5);
    wait_idle("t3a");
    start_fill(32'hFFFF_FFC0, 2, 1, 16'h1234);
    wait_idle("t3b");
    rand_ready = 1'b0;
    check_val("t3_beats", 64'(beats_acc - b0), 64'd64);
    check_val("t3_queue_left", 64'(exp_q.size()), 64'd0);

    // Zero-size starts: no traffic, never busy, one irq each
    i0 = irq_hi; b0 = beats_acc;
    start_fill(32'h0040_0000, 5, 0, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      apb_read(3'd0, rd);
      check_val("t4_busy_h0", 64'(rd[0]), 64'd0);
    end
    start_fill(32'h0040_0000, 0, 3, 16'hFFFF);
    apb_read(3'd0, rd);
    check_val("t4_busy_w0", 64'(rd[0]), 64'd0);
    tick(3);
    check_val("t4_no_beats", 64'(beats_acc - b0), 64'd0);
`ifdef FILL_IRQ_EN
    check_val("t4_irq_cycles", 64'(irq_hi - i0), 64'd2);
`endif

    // Denied ack on the 2nd burst sets sticky err; next start clears it
    deny_at = acks_sent + 1;
    start_fill(32'h0050_0000, 1, 3, 16'h0F0F);
    wait_idle("t5");
    deny_at = -1;
    apb_read(3'd0, rd);
    check_val("t5_status_err", 64'(rd), 64'd2);
    start_fill(32'h0050_0000, 1, 0, 16'h0F0F);
    apb_read(3'd0, rd);
    check_val("t5_err_cleared", 64'(rd), 64'd0);

    // Reset during beat 3 of the first burst, then a normal fill
    b0 = beats_acc;
    start_fill(32'h0060_0000, 4, 1, 16'h3333);
    n = 0;
    while ((beats_acc - b0) < 3 && n < 100) begin
      tick(1);
      n++;
    end
    check_val("t6_reach_beat3", 64'(beats_acc - b0), 64'd3);
    reset = 1'b1;
    #1;
    paddr = 5'd0;
    #1;
    check_val("t6_rst_a_valid", 64'(a_valid), 64'd0);
    check_val("t6_rst_busy", 64'(prdata[0]), 64'd0);
    exp_q.delete();
    ack_due.delete();
    beat_cnt = 0;
    tick(2);
    reset = 1'b0;
    tick(1);
    apb_read(3'd1, rd);
    check_val("t6_dst_cleared", 64'(rd), 64'd0);
    b0 = beats_acc;
    start_fill(32'h0000_2000, 1, 1, 16'hCAFE);
    wait_idle("t6");
    check_val("t6_beats", 64'(beats_acc - b0), 64'd8);
    check_val("t6_queue_left", 64'(exp_q.size()), 64'd0);
    apb_read(3'd0, rd);
    check_val("t6_status", 64'(rd), 64'd0);

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_fill.md
# framebuffer_fill

Hardware rectangle-fill engine for the RGB565 framebuffer that the video controller scans out. The CPU programs it over APB; it writes 64-byte blocks into RAM over a TileLink-UL PutFullData master port. This moves large clears and solid-colour fills off the CPU. It sits upstream of the video controller's graphic plane and shares the framebuffer line layout: 4096-byte line stride, 32 pixels per 64-byte block.

## Interface
- No parameters.
- clk  in  1  system clock (same domain as the video controller's `clk`)
- reset  in  1  asynchronous, active-high reset
- apb_PADDR  in  5  register select, using bits [4:2]
- apb_PSEL, apb_PENABLE, apb_PWRITE  in  1  APB control
- apb_PWDATA  in  32  write data
- apb_PREADY  out  1  constant 1
- apb_PRDATA  out  32  read data, combinational from PADDR[4:2]
- tl_bus_a_valid  out  1  A-channel beat valid
- tl_bus_a_ready  in  1  A-channel ready
- tl_bus_a_payload_opcode/param/source/size  out  3 each  opcode=0 (PutFullData), param=0, source=burst tag, size=6
- tl_bus_a_payload_address  out  32  block address, 64-byte aligned
- tl_bus_a_payload_data  out  64  {4{color}}
- tl_bus_a_payload_mask  out  8  constant 8'hFF
- tl_bus_d_valid  in  1  D-channel AccessAck valid
- tl_bus_d_ready  out  1  constant 1
- tl_bus_d_payload_denied  in  1  error flag
- Other D fields: accepted and ignored.
- irq  out  1  completion pulse; present only with FILL_IRQ_EN

## Operation
- Registers, selected by PADDR[4:2]:
  - 0 CTRL/STATUS: a write with bit0=1 starts a fill. Reads return {30'b0, err, busy}.
  - 1 DST: byte address bits [31:6]; bits [5:0] read as 0.
  - 2 SIZE: width_blocks in [6:0] (1..127), height in [25:16] (1..1023).
  - 3 COLOR: RGB565 value in [15:0].
- While busy, writes to registers 0–3 are ignored.
- Start with width_blocks==0 or height==0: no bus traffic; busy stays 0; the irq pulse still fires.
- Start clears err.
- States:
  - IDLE: on a valid start, load row_base=DST, col=0, row=0, beat=0, outstanding=0; go to SEND.
  - SEND: assert a_valid. Address = row_base + col*64, where the column offset wraps within the 32-bit sum. Beat advances on a_valid&a_ready. After beat 7 is accepted:
    - outstanding increments.
    - col increments. When col reaches width_blocks: col=0, row_base += 4096, row increments.
    - If every block has been sent, go to DRAIN.
    - Otherwise, if outstanding (after this increment) == 4, go to STALL; else stay in SEND with beat=0.
  - STALL: a_valid=0; return to SEND when outstanding < 4.
  - DRAIN: a_valid=0; go to IDLE when outstanding==0.
- Each d_valid decrements outstanding. If a decrement coincides with an increment, outstanding is unchanged. d_valid with denied=1 sets err sticky; the fill continues.
- Source = 2-bit block counter modulo 4, zero-extended to 3 bits.
- Address, data, source and size stay stable for all 8 beats of a burst while a_valid is high and ready is low.
- busy = (state != IDLE).
- Reset mid-fill: everything returns to the reset values immediately. Acks still in flight are absorbed because d_ready=1.

## Timing
- Reset values:
  - a_valid=0, address=0, irq=0, state IDLE.
  - DST, SIZE, COLOR registers: 0.
  - err=0, outstanding=0.
- Start accepted at edge N: busy=1 and a_valid=1 from N+1.
- Sustained throughput with ready=1 and acks returning promptly: 1 beat per clk, so 8 clk per block.
- Completion: the DRAIN→IDLE edge drops busy.
- irq: high for exactly one clk, in the cycle after busy falls, or the cycle after a zero-size start.

## Configuration
- FILL_IRQ_EN defined: the irq port exists with the pulse behaviour above.
- Not defined: the port and its logic are absent; software polls STATUS.busy.

## Structure
- Shared package `fill_pkg`:
  - state enum {IDLE, SEND, STALL, DRAIN}
  - register indices
  - LINE_STRIDE=4096
  - MAX_OUTSTANDING=4
  - TL opcode constants PUT_FULL=0 and ACCESS_ACK=0, shared with other TL masters
- One natural sub-module, `fill_apb_regs`: register file, start/ignore-while-busy logic, PRDATA mux.
- The FSM, address generation and outstanding counter stay in the top module.

## Test plan
- DST=0x0010_0000, width=2, height=2, COLOR=0xF800, ready=1, ack 3 clk after each last beat:
  - 4 bursts at 0x100000, 0x100040, 0x101000, 0x101040.
  - data=64'hF800F800F800F800 on every beat, 32 beats total.
  - busy falls after the 4th ack.
- Acks withheld, width=8, height=1: exactly 4 bursts issued, then a_valid=0. Releasing one ack resumes the 5th burst.
- Random a_ready toggling during a burst: address, data and source stay stable until the beat is accepted; exactly 8 beats per burst.
- Start with height=0: no A traffic, busy never 1, irq pulses once (FILL_IRQ_EN).
- Ack with denied=1 on the 2nd burst: STATUS reads 0b10 after completion; a new start clears err.
- Assert reset during SEND beat 3: a_valid=0 and busy=0 immediately. A later fill, DST=0x2000, width=1, height=1, completes normally.
